// File: rtl/abc_ramrd_pkg.sv
// Shared types and default sizes for the CoreABC scratch-RAM stream reader.
package abc_ramrd_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH  = 8;
  localparam int unsigned FIFO_DEPTH     = 2;
  localparam int unsigned FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/abc_ramrd_skid_fifo.sv
// Two-entry skid FIFO; the head lives in its own register so the stream data
// output comes straight from a flop.
module abc_ramrd_skid_fifo
  import abc_ramrd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o
);

  localparam logic [FIFO_CNT_W-1:0] ONE = FIFO_CNT_W'(1);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) head_d = din_i;
          else               tail_d = din_i;
          count_d = count_q + ONE;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - ONE;
        end
        2'b11: begin
          // Count unchanged; the new byte lands behind whatever remains.
          if (count_q == ONE) begin
            head_d = din_i;
          end else begin
            head_d = tail_q;
            tail_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;
  assign valid_o = (count_q != '0);

endmodule

// File: rtl/abc_ram_stream_reader.sv
// Read-side sequencer for the 128x8 CoreABC scratch RAM: walks an address range
// and streams bytes out on valid/ready. Optional ABORT input under ABC_RAMRD_ABORT_EN.
module abc_ram_stream_reader
  import abc_ramrd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  rclk_i,
  input  logic                  resetn_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rd_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
`ifdef ABC_RAMRD_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  done_o
);

  localparam int unsigned CRD_W = FIFO_CNT_W + 1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  rptr_q, rptr_d;
  logic [LEN_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic                   inflight_q, inflight_d;
  logic                   done_q, done_d;

  logic                   pop_c;
  logic                   flush_c;
  logic                   credit_ok_c;
  logic                   fifo_valid;
  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic [DATA_WIDTH-1:0]  fifo_head;

  assign pop_c = fifo_valid & m_ready_i;
  // Never let buffered plus in-flight bytes exceed the FIFO once this cycle's pop retires.
  assign credit_ok_c = (CRD_W'(fifo_count) + CRD_W'(inflight_q)) <
                       (CRD_W'(FIFO_DEPTH) + CRD_W'(pop_c));

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    inflight_d  = 1'b0;
    done_d      = 1'b0;
    flush_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            state_d     = RUN;
            rptr_d      = start_addr_i;
            issue_cnt_d = length_i;
            beat_cnt_d  = length_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if ((issue_cnt_q != '0) && credit_ok_c) begin
          rptr_d      = rptr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
          inflight_d  = 1'b1;
        end
        if (pop_c) begin
          beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
          if (beat_cnt_q == LEN_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
`ifdef ABC_RAMRD_ABORT_EN
        // A final pop wins over abort so exactly one DONE is produced.
        if (abort_i && !(pop_c && (beat_cnt_q == LEN_WIDTH'(1)))) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          inflight_d  = 1'b0;
          flush_c     = 1'b1;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      rptr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rptr_q      <= rptr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

  abc_ramrd_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i    (rclk_i),
    .resetn_i (resetn_i),
    .flush_i  (flush_c),
    .push_i   (inflight_q),
    .din_i    (rd_i),
    .pop_i    (pop_c),
    .count_o  (fifo_count),
    .head_o   (fifo_head),
    .valid_o  (fifo_valid)
  );

  assign raddr_o   = rptr_q;
  assign m_data_o  = fifo_head;
  assign m_valid_o = fifo_valid;
  assign m_last_o  = fifo_valid & (beat_cnt_q == LEN_WIDTH'(1));
  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;

endmodule

// File: tb/tb_abc_ram_stream_reader.sv
// Bench for abc_ram_stream_reader: behavioural 128x8 RAM plus a byte-queue reference model.
module tb_abc_ram_stream_reader;

  logic       clk = 1'b0;
  logic       resetn_i;
  logic       start_i;
  logic [6:0] start_addr_i;
  logic [7:0] length_i;
  logic [6:0] raddr_o;
  logic [7:0] rd_i;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_last_o;
  logic       busy_o;
  logic       done_o;
  logic       abort_i;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] ram [128];

  always #5 clk = ~clk;
  always @(posedge clk) rd_i <= ram[raddr_o];

  abc_ram_stream_reader dut (
    .rclk_i       (clk),
    .resetn_i     (resetn_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .length_i     (length_i),
    .raddr_o      (raddr_o),
    .rd_i         (rd_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o),
`ifdef ABC_RAMRD_ABORT_EN
    .abort_i      (abort_i),
`endif
    .done_o       (done_o)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    int idx;
    idx = (cyc - 1) % 4;
    case (mode)
      0:       return 1'b1;
      1:       return (idx == 0) || (idx == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transfer: expected bytes come from the RAM contents at the walked addresses.
  task automatic run_xfer(input logic [6:0] a, input logic [7:0] n, input int mode, input bit dbl_start);
    logic [7:0] q[$];
    logic [7:0] prev_data;
    bit         prev_stall;
    bit         fin;
    int         cyc;
    int         first_v;
    int         done_cyc;
    for (int i = 0; i < int'(n); i++) q.push_back(ram[7'(int'(a) + i)]);
    fin        = (n == 8'd0);
    prev_stall = 1'b0;
    prev_data  = '0;
    first_v    = -1;
    done_cyc   = -1;
    start_i      = 1'b1;
    start_addr_i = a;
    length_i     = n;
    next_cycle();
    start_i = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 3000) begin
      if (cyc == 1 && n != 8'd0) check_eq("raddr_start", 32'(raddr_o), 32'(a));
      if (fin) begin
        check_eq("done_pulse", 32'(done_o), 1);
        check_eq("busy_end", 32'(busy_o), 0);
        check_eq("valid_end", 32'(m_valid_o), 0);
        done_cyc = cyc;
      end else begin
        check_eq("done_early", 32'(done_o), 0);
        check_eq("busy_run", 32'(busy_o), 1);
        if (prev_stall) begin
          check_eq("stall_valid", 32'(m_valid_o), 1);
          check_eq("stall_data", 32'(m_data_o), 32'(prev_data));
        end
        m_ready_i = ready_pat(mode, cyc);
        if (m_valid_o) begin
          if (first_v < 0) first_v = cyc;
          if (q.size() == 0) begin
            check_eq("extra_beat", 32'(m_valid_o), 0);
          end else begin
            check_eq("beat_data", 32'(m_data_o), 32'(q[0]));
            check_eq("beat_last", 32'(m_last_o), 32'(q.size() == 1));
            if (m_ready_i) begin
              void'(q.pop_front());
              if (q.size() == 0) fin = 1'b1;
            end
          end
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
      end
      if (done_cyc < 0) begin
        if (dbl_start && cyc == 2) begin
          start_i      = 1'b1;
          start_addr_i = 7'($urandom);
          length_i     = 8'($urandom_range(1, 255));
        end else begin
          start_i = 1'b0;
        end
        next_cycle();
        cyc++;
      end
    end
    start_i = 1'b0;
    if (done_cyc < 0) check_eq("timeout", 0, 1);
    if (mode == 0 && n != 8'd0) begin
      check_eq("first_valid_cyc", 32'(first_v), 3);
      check_eq("done_cyc", 32'(done_cyc), 32'(int'(n) + 3));
    end
    if (mode == 0 && n == 8'd0) check_eq("done_cyc_len0", 32'(done_cyc), 1);
    next_cycle();
    check_eq("quiet_done", 32'(done_o), 0);
    check_eq("quiet_valid", 32'(m_valid_o), 0);
    check_eq("quiet_busy", 32'(busy_o), 0);
  endtask

  initial begin
    int beats;
    resetn_i     = 1'b0;
    start_i      = 1'b0;
    start_addr_i = '0;
    length_i     = '0;
    m_ready_i    = 1'b1;
    abort_i      = 1'b0;
    for (int i = 0; i < 128; i++) ram[i] = 8'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_raddr", 32'(raddr_o), 0);
    check_eq("rst_data", 32'(m_data_o), 0);
    check_eq("rst_valid", 32'(m_valid_o), 0);
    check_eq("rst_last", 32'(m_last_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    resetn_i = 1'b1;
    next_cycle();

    run_xfer(7'h10, 8'd4, 0, 1'b0);
    run_xfer(7'h7E, 8'd4, 0, 1'b0);
    run_xfer(7'h40, 8'd8, 1, 1'b1);
    run_xfer(7'h05, 8'd0, 0, 1'b0);
    run_xfer(7'h00, 8'd1, 0, 1'b0);

    // Reset for one cycle after three beats have been accepted.
    start_i = 1'b1; start_addr_i = 7'h20; length_i = 8'd8;
    next_cycle();
    start_i = 1'b0; m_ready_i = 1'b1;
    beats = 0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      if (m_valid_o) beats++;
      if (beats < 3) next_cycle();
    end
    check_eq("rst_mid_beats", 32'(beats), 3);
    resetn_i = 1'b0;
    next_cycle();
    check_eq("rmid_raddr", 32'(raddr_o), 0);
    check_eq("rmid_data", 32'(m_data_o), 0);
    check_eq("rmid_valid", 32'(m_valid_o), 0);
    check_eq("rmid_last", 32'(m_last_o), 0);
    check_eq("rmid_busy", 32'(busy_o), 0);
    check_eq("rmid_done", 32'(done_o), 0);
    resetn_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      check_eq("rpost_done", 32'(done_o), 0);
      check_eq("rpost_valid", 32'(m_valid_o), 0);
    end
    run_xfer(7'h30, 8'd5, 0, 1'b0);

`ifdef ABC_RAMRD_ABORT_EN
    start_i = 1'b1; start_addr_i = 7'h50; length_i = 8'd10;
    next_cycle();
    start_i = 1'b0; m_ready_i = 1'b1;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      if (m_valid_o) begin
        check_eq("ab_last", 32'(m_last_o), 0);
        beats++;
      end
      next_cycle();
    end
    abort_i = 1'b1; m_ready_i = 1'b0;
    next_cycle();
    abort_i = 1'b0;
    check_eq("ab_valid", 32'(m_valid_o), 0);
    check_eq("ab_done", 32'(done_o), 1);
    check_eq("ab_last_after", 32'(m_last_o), 0);
    check_eq("ab_busy", 32'(busy_o), 0);
    next_cycle();
    check_eq("ab_done_once", 32'(done_o), 0);
    check_eq("ab_valid_quiet", 32'(m_valid_o), 0);
    m_ready_i = 1'b1;
`endif

    for (int t = 0; t < 20; t++) begin
      int len;
      for (int i = 0; i < 128; i++) ram[i] = 8'($urandom);
      len = (t % 5 == 4) ? int'($urandom_range(129, 200)) : int'($urandom_range(0, 40));
      run_xfer(7'($urandom), 8'(len), int'($urandom_range(0, 2)), (len != 0) && t[0]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
